stream_fifo: RTL and testbench

Parametrised synchronous stream FIFO, the successor to the single-channel pointer FIFO used in the FIR datapath. It buffers `WIDTH`-bit words between an AXI-Stream-style producer and consumer using valid/ready handshakes on both sides. It supports any `DEPTH ≥ 2`, including non-power-of-two depths, and operates in first-word-fall-through (FWFT) mode. It also adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky error flags. It sits between the AXI-Stream slave ports and the FIR tap/data engines.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/stream_fifo_mod_ptr.sv | 40 ++++
 rtl/stream_fifo.sv | 120 ++++++++++++
 tb/tb_stream_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the stream FIFO.
// Holds pointer/level width functions and default parameter values.
package fifo_pkg;

    // Pointer width for a modulo-d counter; never narrower than 1 bit.
    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    // Level width: must represent 0..d inclusive.
    function automatic int lvl_w(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_LW        = lvl_w(DEF_DEPTH);
    localparam int DEF_AFULL_TH  = DEF_DEPTH - 1;
    localparam int DEF_AEMPTY_TH = 1;

endpackage

// File: rtl/stream_fifo_mod_ptr.sv
// Modulo-DEPTH pointer: wraps DEPTH-1 -> 0, no power-of-two assumption.
// Ports: clk, reset (sync, active-high), clr (sync clear), inc, ptr.
module mod_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/stream_fifo.sv
// FWFT valid/ready stream FIFO with level, threshold flags, flush, sticky errors.
// Ports: clk, reset, flush, s_valid/s_ready/s_data, m_valid/m_ready/m_data,
// level, almost_full, almost_empty, overflow, underflow.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIDTH-1:0]          m_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF   = LW'(AFULL_TH);
    localparam logic [LW-1:0] AE   = LW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [LW-1:0] level_q, level_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic          wr_en, rd_en;

    // Ready/valid come only from registered level: no m_ready -> s_ready path.
    assign s_ready = ~reset & (level_q != FULL);
    assign m_valid = ~reset & (level_q != '0);

    assign push  = s_valid & s_ready;
    assign pop   = m_valid & m_ready;
    assign wr_en = push & ~flush;
    assign rd_en = pop & ~flush;

    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q | (s_valid & ~s_ready);
        udf_d   = udf_q | (m_ready & ~m_valid);
        if (flush) begin
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (push & ~pop) begin
            level_d = level_q + LW'(1);
        end else if (pop & ~push) begin
            level_d = level_q - LW'(1);
        end
        // Flags follow next-state level so they stay coherent with level.
        afull_d  = (level_d >= AF);
        aempty_d = (level_d <= AE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= s_data;
        end
    end

    mod_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    mod_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    assign m_data       = m_valid ? mem_q[rd_ptr] : '0;
    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Randomised + directed bench for stream_fifo against a queue model.
// DUT: WIDTH=16, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
module tb_stream_fifo;

    localparam int W   = 16;
    localparam int D   = 5;
    localparam int AFT = 4;
    localparam int AET = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [2:0]   level;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;
    logic         underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    always #5 clk = ~clk;

    stream_fifo #(
        .WIDTH(W), .DEPTH(D), .AFULL_TH(AFT), .AEMPTY_TH(AET)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check all outputs against the model, then advance.
    task automatic step(input logic sv, input logic [W-1:0] sd,
                        input logic mr, input logic fl, input logic rs);
        logic         e_sr;
        logic         e_mv;
        logic [W-1:0] e_md;
        int           n;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        reset   = rs;
        #1;
        n    = q.size();
        e_sr = !rs && (n != D);
        e_mv = !rs && (n != 0);
        e_md = '0;
        if (e_mv) e_md = q[0];
        chk("s_ready", {31'b0, s_ready}, {31'b0, e_sr});
        chk("m_valid", {31'b0, m_valid}, {31'b0, e_mv});
        chk("m_data", {16'b0, m_data}, {16'b0, e_md});
        chk("level", {29'b0, level}, n);
        chk("almost_full", {31'b0, almost_full}, {31'b0, n >= AFT});
        chk("almost_empty", {31'b0, almost_empty}, {31'b0, n <= AET});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("underflow", {31'b0, underflow}, {31'b0, m_udf});
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (sv && !e_sr) m_ovf = 1'b1;
            if (mr && !e_mv) m_udf = 1'b1;
            if (mr && e_mv) void'(q.pop_front());
            if (sv && e_sr) q.push_back(sd);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_ae", {31'b0, almost_empty}, 32'd1);

        for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_level", {29'b0, level}, 32'd5);
        chk("fill_af", {31'b0, almost_full}, 32'd1);
        chk("fill_sready", {31'b0, s_ready}, 32'd0);
        step(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        chk("fill_ovf", {31'b0, overflow}, 32'd1);

        for (int i = 1; i <= 5; i++) begin
            chk("drain_data", {16'b0, m_data}, i);
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
        chk("wrap_aa", {16'b0, m_data}, 32'h00AA);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("wrap_bb", {16'b0, m_data}, 32'h00BB);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, W'(16'h200 + i), 1'b1, 1'b0, 1'b0);
        chk("simul_level", {29'b0, level}, 32'd3);
        chk("simul_head", {16'b0, m_data}, 32'h0207);

        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("lat_valid", {31'b0, m_valid}, 32'd1);
        chk("lat_data", {16'b0, m_data}, 32'h1234);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("lat_ae", {31'b0, almost_empty}, 32'd1);
        chk("lat_level", {29'b0, level}, 32'd0);

        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h300 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_level", {29'b0, level}, 32'd0);
        chk("flush_mdata", {16'b0, m_data}, 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_udf", {31'b0, underflow}, 32'd1);

        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h400 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0BAD, 1'b1, 1'b0, 1'b1);
        chk("rst_level", {29'b0, level}, 32'd0);
        chk("rst_udf", {31'b0, underflow}, 32'd0);
        step(1'b1, 16'h0BEE, 1'b0, 1'b0, 1'b0);
        chk("rst_bee", {16'b0, m_data}, 32'h0BEE);
        idle();

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
